mips32_run_ctrl: RTL

Synthesizable run controller for the mips32 core. It takes over reset sequencing and run-length control from the bench's fixed delays: it holds the core in reset for a set number of cycles, gates execution with a clock enable, and stops on a halt instruction or a cycle timeout. Every register write-back is captured into a parametrised trace FIFO that a bench or debug port drains through a valid/ready handshake.

---
 rtl/mips32_run_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mips32_run_ctrl.sv
// mips32_run_ctrl: reset sequencing, run-length control and write-back trace FIFO for the
// mips32 core. Holds the core in reset for RST_CYCLES cycles after start, runs it until a
// halt instruction or a MAX_CYCLES budget, and captures every register commit into a
// DEPTH-entry trace FIFO drained through trValid/trReady.
// Build option: define MIPS32_TRACE_STALL_EN to stall the core instead of dropping commits
// when the trace FIFO is full.
module mips32_run_ctrl #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     DEPTH      = 8,
    parameter int unsigned     RST_CYCLES = 4,
    parameter int unsigned     MAX_CYCLES = 1024,
    parameter int unsigned     CNT_W      = 16,
    parameter logic [WIDTH-1:0] HALT_INSTR = 32'h0000000C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             coreRst,
    output logic             coreEn,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] pc,
    input  logic             regWrite,
    input  logic [4:0]       writeReg,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycleCount,
    output logic             trValid,
    input  logic             trReady,
    output logic [WIDTH-1:0] trPc,
    output logic [4:0]       trReg,
    output logic [WIDTH-1:0] trData,
    output logic [CNT_W-1:0] dropCount
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StResetCore,
        StRun,
        StDone
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [4:0]       rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    state_e           state_q, state_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             timeout_q, timeout_d;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  occ_q, occ_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic is_halt;
    logic commit_req;
    logic fifo_full;
    logic tr_pop;
    logic stall;
    logic run_en;
    logic push_req;
    logic push;
    logic drop;

    // Commit qualification and FIFO handshake decode shared by the FSM and the FIFO.
    always_comb begin
        is_halt    = (instr == HALT_INSTR);
        commit_req = regWrite && !is_halt && (writeReg != 5'd0);
        fifo_full  = (occ_q == OccW'(DEPTH));
        tr_pop     = (occ_q != '0) && trReady;
`ifdef MIPS32_TRACE_STALL_EN
        // Hold the core for a cycle rather than lose a commit that has nowhere to go.
        stall      = (state_q == StRun) && fifo_full && !tr_pop && commit_req;
`else
        stall      = 1'b0;
`endif
        run_en     = (state_q == StRun) && !stall;
        push_req   = run_en && commit_req;
        push       = push_req && (!fifo_full || tr_pop);
        drop       = push_req && fifo_full && !tr_pop;
    end

    // Run sequencing: next state, reset-hold counter, cycle budget, drop counter, timeout flag.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        timeout_d   = timeout_q;

        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                cycle_cnt_d = '0;
                drop_cnt_d  = '0;
                timeout_d   = 1'b0;
                if (start) begin
                    state_d   = StResetCore;
                    rst_cnt_d = '0;
                end
            end
            StResetCore: begin
                if (rst_cnt_q == RstW'(RST_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + RstW'(1);
                end
            end
            StRun: begin
                if (run_en) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    // Halt takes priority over the budget expiring in the same cycle.
                    if (is_halt) begin
                        state_d = StDone;
                    end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d     = StResetCore;
                    rst_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    drop_cnt_d  = '0;
                    timeout_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Trace FIFO pointer, occupancy and storage update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: pc, rd: writeReg, data: writeData};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (tr_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, tr_pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control and pointer state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            drop_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            timeout_q   <= timeout_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Trace storage needs no reset: entries are only read while occupancy is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign coreRst    = (state_q == StIdle) || (state_q == StResetCore);
    assign coreEn     = run_en;
    assign busy       = (state_q == StResetCore) || (state_q == StRun);
    assign done       = (state_q == StDone);
    assign timeout    = timeout_q;
    assign cycleCount = cycle_cnt_q;
    assign dropCount  = drop_cnt_q;
    assign trValid    = (occ_q != '0);
    assign trPc       = mem_q[rd_ptr_q].pc;
    assign trReg      = mem_q[rd_ptr_q].rd;
    assign trData     = mem_q[rd_ptr_q].data;

endmodule
